// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT sample loader and its output stage.
package fft_pkg;

   localparam int M         = 9;
   localparam int BIT_WIDTH = 16;
   localparam int N         = 2**M;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, UNLOAD} fft_state_t;

   typedef struct packed {
      logic signed [BIT_WIDTH-1:0] imag;
      logic signed [BIT_WIDTH-1:0] re;
   } cplx_t;

   function automatic logic [M-1:0] bitrev(input logic [M-1:0] a);
      logic [M-1:0] r;
      r = '0;
      for (int i = 0; i < M; i++) begin
         r[i] = a[M-1-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/fft_out_stage.sv
// Result-bank reader: issues rd_en, tracks the 1-cycle RAM latency and presents bins under valid/ready.
module fft_out_stage
   import fft_pkg::*;
#(
   parameter int L = N
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     active_i,
   output logic                     rd_en_o,
   output logic [M-1:0]             rd_adr_o,
   input  logic [2*BIT_WIDTH-1:0]   rd_data_i,
   output logic                     m_valid_o,
   output logic [2*BIT_WIDTH-1:0]   m_data_o,
   output logic [M-1:0]             m_index_o,
   output logic                     m_last_o,
   input  logic                     m_ready_i,
   output logic                     frame_done_o
);

   localparam logic [M:0] L_CNT    = (M+1)'(L);
   localparam logic [M:0] LAST_CNT = (M+1)'(L-1);

   logic [M:0]   rd_cnt_q;
   logic         m_valid_q;
   logic         m_last_q;
   logic [M-1:0] m_index_q;
   logic         fresh_q;
   cplx_t        hold_q;
   logic         more_to_read;
   logic         rd_en;
   logic         frame_done;

   assign more_to_read = active_i && (rd_cnt_q != L_CNT);
   assign rd_en        = more_to_read && (!m_valid_q || m_ready_i);
   assign frame_done   = m_valid_q && m_ready_i && m_last_q;

   // The bin arriving from the RAM this cycle is presented directly; hold_q keeps it while stalled.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_cnt_q  <= '0;
         m_valid_q <= 1'b0;
         m_last_q  <= 1'b0;
         m_index_q <= '0;
         fresh_q   <= 1'b0;
         hold_q    <= '0;
      end else begin
         fresh_q <= rd_en;
         if (fresh_q) begin
            hold_q <= rd_data_i;
         end
         if (rd_en) begin
            rd_cnt_q  <= rd_cnt_q + 1'b1;
            m_valid_q <= 1'b1;
            m_index_q <= rd_cnt_q[M-1:0];
            m_last_q  <= (rd_cnt_q == LAST_CNT);
         end else if (m_valid_q && m_ready_i) begin
            m_valid_q <= 1'b0;
            m_last_q  <= 1'b0;
         end
         if (frame_done) begin
            rd_cnt_q <= '0;
         end
      end
   end

   assign rd_en_o      = rd_en;
   assign rd_adr_o     = rd_cnt_q[M-1:0];
   assign m_valid_o    = m_valid_q;
   assign m_data_o     = fresh_q ? rd_data_i : hold_q;
   assign m_index_o    = m_index_q;
   assign m_last_o     = m_last_q;
   assign frame_done_o = frame_done;

endmodule

// File: rtl/fft_sample_loader.sv
// Loads a real sample frame bit-reversed into FFT bank 0, runs the AGU, then streams the spectrum out.
// HALF_SPECTRUM_EN: when defined only bins 0..N/2-1 are streamed.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | accepting N samples into bank 0
// RUN    | AGU enabled, waiting for done
// UNLOAD | reading result bank and streaming bins
module fft_sample_loader
   import fft_pkg::*;
(
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     start_i,
   input  logic                     s_valid_i,
   input  logic [BIT_WIDTH-1:0]     s_data_i,
   output logic                     s_ready_o,
   output logic                     load_o,
   output logic                     enable_o,
   input  logic                     done_i,
   output logic                     we0_o,
   output logic [M-1:0]             wr_adr_o,
   output logic [2*BIT_WIDTH-1:0]   wr_data_o,
   output logic                     rd_bank_o,
   output logic [M-1:0]             rd_adr_o,
   output logic                     rd_en_o,
   input  logic [2*BIT_WIDTH-1:0]   rd_data_i,
   output logic                     m_valid_o,
   output logic [2*BIT_WIDTH-1:0]   m_data_o,
   output logic [M-1:0]             m_index_o,
   output logic                     m_last_o,
   input  logic                     m_ready_i,
   output logic                     busy_o
);

`ifdef HALF_SPECTRUM_EN
   localparam int L = N/2;
`else
   localparam int L = N;
`endif

   localparam logic RD_BANK = ((M % 2) == 1);

   fft_state_t   state_q;
   logic [M-1:0] cnt_q;
   logic         s_ready_q;
   logic         load_q;
   logic         enable_q;
   logic         busy_q;
   logic         we0;
   logic         frame_done;
   cplx_t        wr_word;

   assign we0 = s_valid_i && s_ready_q;

   always_comb begin
      wr_word = '0;
      if (we0) begin
         wr_word.re = s_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         s_ready_q <= 1'b0;
         load_q    <= 1'b0;
         enable_q  <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start_i) begin
                  state_q   <= LOAD;
                  cnt_q     <= '0;
                  s_ready_q <= 1'b1;
                  load_q    <= 1'b1;
                  busy_q    <= 1'b1;
               end
            end
            LOAD: begin
               if (we0) begin
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == '1) begin
                     state_q   <= RUN;
                     s_ready_q <= 1'b0;
                     load_q    <= 1'b0;
                     enable_q  <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (done_i) begin
                  state_q  <= UNLOAD;
                  enable_q <= 1'b0;
               end
            end
            UNLOAD: begin
               if (frame_done) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   fft_out_stage #(
      .L (L)
   ) u_out_stage (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .active_i     (state_q == UNLOAD),
      .rd_en_o      (rd_en_o),
      .rd_adr_o     (rd_adr_o),
      .rd_data_i    (rd_data_i),
      .m_valid_o    (m_valid_o),
      .m_data_o     (m_data_o),
      .m_index_o    (m_index_o),
      .m_last_o     (m_last_o),
      .m_ready_i    (m_ready_i),
      .frame_done_o (frame_done)
   );

   assign s_ready_o = s_ready_q;
   assign load_o    = load_q;
   assign enable_o  = enable_q;
   assign we0_o     = we0;
   assign wr_adr_o  = bitrev(cnt_q);
   assign wr_data_o = wr_word;
   assign rd_bank_o = RD_BANK;
   assign busy_o    = busy_q;

endmodule
